// File: rtl/app_axi_slave.sv
// AXI4-Lite slave endpoint that terminates single-beat reads and writes into a local
// register bank of NUM_REGS words. The write and read channels are handled independently.
module app_axi_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // Write address channel
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  // Write data channel
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  // Write response channel
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  // Read address channel
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic                      arvalid,
  output logic                      arready,
  // Read data channel
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready
);

  localparam int unsigned StrbW   = DATA_WIDTH / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);
  localparam int unsigned IdxW    = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] RangeLimit = ADDR_WIDTH'(NUM_REGS * StrbW);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {
    WrIdle,
    WrAddrHeld,
    WrDataHeld,
    WrResp
  } wr_state_e;

  typedef enum logic {
    RdIdle,
    RdResp
  } rd_state_e;

  function automatic logic [IdxW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    return addr[AddrLsb +: IdxW];
  endfunction

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    return addr < RangeLimit;
  endfunction

  // ---------------------------------------------------------------------------
  // Register bank and write-side state
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  wr_state_e             wr_state_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [StrbW-1:0]      wstrb_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit_en;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [StrbW-1:0]      commit_strb;
  logic                  commit_ok;
  logic [IdxW-1:0]       commit_idx;
  logic [1:0]            commit_resp;

  assign aw_hs = awvalid & awready_q;
  assign w_hs  = wvalid & wready_q;

  // A commit happens on the edge of whichever handshake completes the pair.
  always_comb begin
    commit_en = 1'b0;
    case (wr_state_q)
      WrIdle:     commit_en = aw_hs & w_hs;
      WrAddrHeld: commit_en = w_hs;
      WrDataHeld: commit_en = aw_hs;
      default:    commit_en = 1'b0;
    endcase
  end

  assign commit_addr = (wr_state_q == WrAddrHeld) ? awaddr_q : awaddr;
  assign commit_data = (wr_state_q == WrDataHeld) ? wdata_q  : wdata;
  assign commit_strb = (wr_state_q == WrDataHeld) ? wstrb_q  : wstrb;
  assign commit_ok   = addr_ok(commit_addr);
  assign commit_idx  = addr_idx(commit_addr);
  assign commit_resp = commit_ok ? RespOkay : RespSlvErr;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit_en && commit_ok) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (commit_strb[b]) begin
          regs_q[commit_idx][b*8 +: 8] <= commit_data[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM; readies and bvalid are registered alongside the state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state_q <= WrIdle;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
    end else begin
      case (wr_state_q)
        WrIdle: begin
          if (commit_en) begin
            wr_state_q <= WrResp;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= commit_resp;
          end else if (aw_hs) begin
            wr_state_q <= WrAddrHeld;
            awaddr_q   <= awaddr;
            awready_q  <= 1'b0;
          end else if (w_hs) begin
            wr_state_q <= WrDataHeld;
            wdata_q    <= wdata;
            wstrb_q    <= wstrb;
            wready_q   <= 1'b0;
          end
        end
        WrAddrHeld, WrDataHeld: begin
          if (commit_en) begin
            wr_state_q <= WrResp;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= commit_resp;
          end
        end
        WrResp: begin
          if (bready) begin
            wr_state_q <= WrIdle;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
          end
        end
        default: begin
          wr_state_q <= WrIdle;
          awready_q  <= 1'b1;
          wready_q   <= 1'b1;
          bvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

  // ---------------------------------------------------------------------------
  // Read FSM. The bank is sampled with its pre-edge value, so a read colliding
  // with a commit to the same word returns the old contents.
  // ---------------------------------------------------------------------------
  rd_state_e             rd_state_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  ar_hs;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_word;

  assign ar_hs   = arvalid & arready_q;
  assign rd_ok   = addr_ok(araddr);
  assign rd_word = rd_ok ? regs_q[addr_idx(araddr)] : '0;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state_q <= RdIdle;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
    end else begin
      case (rd_state_q)
        RdIdle: begin
          if (ar_hs) begin
            rd_state_q <= RdResp;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rd_word;
            rresp_q    <= rd_ok ? RespOkay : RespSlvErr;
          end
        end
        RdResp: begin
          if (rready) begin
            rd_state_q <= RdIdle;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
          end
        end
        default: begin
          rd_state_q <= RdIdle;
          arready_q  <= 1'b1;
          rvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_app_axi_slave.sv
// Self-checking bench for app_axi_slave: directed cases followed by randomized traffic,
// all compared against a word-array model of the register space.
module tb_app_axi_slave;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NR = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  always #5 aclk = ~aclk;

  app_axi_slave #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REGS  (NR)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready),
    .araddr (araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rvalid (rvalid),
    .rready (rready)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [31:0] model [NR];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Reference model: a byte-addressed window of NR 32-bit words starting at 0.
  function automatic bit in_range(input logic [31:0] a);
    return a < NR * 4;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_range(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    return in_range(a) ? model[a / 4] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_range(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[a / 4][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NR); i++) model[i] = 32'h0;
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W; hold = bready-low cycles.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int hold);
    int n;
    logic [1:0] resp0;
    n = (lead < 0) ? -lead : lead;
    check("wr_awready_idle", 64'(awready), 64'd1);
    check("wr_wready_idle", 64'(wready), 64'd1);
    bready = (hold == 0);
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    if (n == 0) begin
      awvalid = 1'b1;
      wvalid  = 1'b1;
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end else begin
      if (lead > 0) wvalid = 1'b1;
      else awvalid = 1'b1;
      tick();
      wvalid  = 1'b0;
      awvalid = 1'b0;
      // Scramble the already-accepted channel so the held copy must be used.
      if (lead > 0) begin
        wdata = $urandom;
        wstrb = 4'($urandom);
      end else begin
        awaddr = $urandom;
      end
      for (int i = 0; i < n; i++) begin
        if (lead > 0) begin
          check("wait_w_wready", 64'(wready), 64'd0);
          check("wait_w_awready", 64'(awready), 64'd1);
        end else begin
          check("wait_aw_awready", 64'(awready), 64'd0);
          check("wait_aw_wready", 64'(wready), 64'd1);
        end
        if (i < n - 1) tick();
      end
      if (lead > 0) begin
        awaddr  = addr;
        awvalid = 1'b1;
      end else begin
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
      end
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
    check("bvalid_rise", 64'(bvalid), 64'd1);
    check("bresp", 64'(bresp), 64'(exp_resp(addr)));
    resp0 = exp_resp(addr);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bvalid_hold", 64'(bvalid), 64'd1);
      check("bresp_hold", 64'(bresp), 64'(resp0));
      check("awready_in_resp", 64'(awready), 64'd0);
      check("wready_in_resp", 64'(wready), 64'd0);
    end
    bready = 1'b1;
    tick();
    check("bvalid_drop", 64'(bvalid), 64'd0);
    check("awready_back", 64'(awready), 64'd1);
    model_write(addr, data, strb);
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold);
    logic [31:0] exp;
    exp = exp_read(addr);
    check("rd_arready_idle", 64'(arready), 64'd1);
    rready  = (hold == 0);
    araddr  = addr;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    araddr  = $urandom;
    check("rvalid_rise", 64'(rvalid), 64'd1);
    check("rdata", 64'(rdata), 64'(exp));
    check("rresp", 64'(rresp), 64'(exp_resp(addr)));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("rvalid_hold", 64'(rvalid), 64'd1);
      check("rdata_hold", 64'(rdata), 64'(exp));
      check("arready_in_resp", 64'(arready), 64'd0);
    end
    rready = 1'b1;
    tick();
    check("rvalid_drop", 64'(rvalid), 64'd0);
    check("arready_back", 64'(arready), 64'd1);
  endtask

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return 32'($urandom_range(0, 71));
  endfunction

  initial begin
    aresetn = 1'b0;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b1;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b1;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;

    check("rst_awready", 64'(awready), 64'd1);
    check("rst_wready", 64'(wready), 64'd1);
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_bresp", 64'(bresp), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);

    // Simultaneous AW/W, then read back.
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(32'h4, 0);
    // W three cycles ahead of AW.
    do_write(32'h8, 32'h11223344, 4'hF, 3, 0);
    do_read(32'h8, 0);
    // Byte strobes, then an empty-strobe no-op.
    do_write(32'hC, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_write(32'hC, 32'h000000AA, 4'h1, -2, 0);
    do_read(32'hC, 0);
    do_write(32'hC, 32'h12345678, 4'h0, 1, 0);
    do_read(32'hC, 0);
    // Out-of-range write must leave the whole bank untouched.
    do_write(32'h40, 32'h55AA55AA, 4'hF, 0, 0);
    for (int i = 0; i < int'(NR); i++) do_read(32'(i * 4), 0);
    do_read(32'h40, 0);
    do_read(32'hFFFF_FFFC, 0);
    // Backpressure on both response channels.
    do_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 5);
    do_read(32'h10, 5);

    // Read and write to the same word on the same edge: read sees old contents.
    do_write(32'h14, 32'h01020304, 4'hF, 0, 0);
    awaddr  = 32'h14;
    wdata   = 32'hA5A5A5A5;
    wstrb   = 4'hF;
    araddr  = 32'h14;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    arvalid = 1'b1;
    bready  = 1'b1;
    rready  = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
    check("coll_bvalid", 64'(bvalid), 64'd1);
    check("coll_rvalid", 64'(rvalid), 64'd1);
    check("coll_rdata_old", 64'(rdata), 64'(exp_read(32'h14)));
    model_write(32'h14, 32'hA5A5A5A5, 4'hF);
    tick();
    check("coll_bvalid_drop", 64'(bvalid), 64'd0);
    check("coll_rvalid_drop", 64'(rvalid), 64'd0);
    do_read(32'h14, 0);

    // Randomized mixed traffic.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write(pick_addr(), $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
      end else begin
        do_read(pick_addr(), int'($urandom_range(0, 2)));
      end
    end

    // Reset while a write sits in the address-held state and a read response is pending.
    do_write(32'h18, 32'h00000077, 4'hF, 0, 0);
    awaddr  = 32'h18;
    awvalid = 1'b1;
    araddr  = 32'h18;
    arvalid = 1'b1;
    rready  = 1'b0;
    tick();
    awvalid = 1'b0;
    arvalid = 1'b0;
    check("pre_rst_awready", 64'(awready), 64'd0);
    check("pre_rst_rvalid", 64'(rvalid), 64'd1);
    aresetn = 1'b0;
    tick();
    check("mid_rst_bvalid", 64'(bvalid), 64'd0);
    check("mid_rst_rvalid", 64'(rvalid), 64'd0);
    check("mid_rst_awready", 64'(awready), 64'd1);
    check("mid_rst_wready", 64'(wready), 64'd1);
    check("mid_rst_arready", 64'(arready), 64'd1);
    aresetn = 1'b1;
    rready  = 1'b1;
    model_reset();
    do_read(32'h18, 0);
    do_write(32'h1C, 32'h0BADCAFE, 4'hF, -1, 0);
    do_read(32'h1C, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
